// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
//
// Loads the serial configuration scan chain of a row of conn_box cells.
// Config words arrive from the bitstream source over a valid/ready handshake
// and are serialised LSB-first onto cfg_si while cfg_en is high. Exactly
// CHAIN_LEN bits are shifted per load; the upper bits of the final word are
// dropped when CHAIN_LEN is not a multiple of WORD_W. One instance per chain.
//
// Optional build macro: CFG_READBACK_EN
//   Defined   : cfg_so is captured on every shift and returned word by word
//               on rb_data with a one-cycle rb_valid strobe.
//   Undefined : rb_data/rb_valid are tied to 0 and no readback logic exists.
//
// Parameters
//   CHAIN_LEN  total config bits in the chain (>= 1)
//   WORD_W     input word width (>= 2)
//
// Ports
//   clk        system clock; chain cells shift on rising edge when cfg_en=1
//   rst_n      asynchronous active-low reset
//   start      begin a load (sampled in IDLE only)
//   abort      cancel a load in progress (wins over handshake and start)
//   in_data    config word
//   in_valid   in_data valid
//   in_ready   word accepted when in_valid & in_ready at a clk edge
//   cfg_si     serial data to chain head (registered)
//   cfg_en     chain shift enable (registered, changes together with cfg_si)
//   cfg_so     serial data from chain tail
//   busy       load in progress (LOAD, SHIFT or DONE)
//   done       one-cycle pulse, load complete
//   rb_data    readback word
//   rb_valid   readback word strobe
// -----------------------------------------------------------------------------
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_si,
  output logic              cfg_en,
  input  logic              cfg_so,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int TB_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W + 1);

  localparam logic [TB_W-1:0] LAST_TBIT = TB_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0] LAST_WBIT = WB_W'(WORD_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [WORD_W-2:0] r_sreg;    // bits of the current word not yet on cfg_si
  logic [WB_W-1:0]   r_wbit;    // index of the bit currently on cfg_si
  logic [TB_W-1:0]   r_tbit;    // bits shifted so far in this load
  logic              r_cfg_si;
  logic              r_cfg_en;
  logic              r_done;

  logic w_abort;
  logic w_accept;
  logic w_last_bit;
  logic w_word_end;

  assign w_abort    = abort && (r_state != S_IDLE);
  // abort masks in_ready so the source never sees a handshake for a word
  // that the controller is about to drop.
  assign in_ready   = (r_state == S_LOAD) && !abort;
  assign w_accept   = in_ready && in_valid;
  assign w_last_bit = (r_tbit == LAST_TBIT);
  assign w_word_end = (r_wbit == LAST_WBIT);

  assign cfg_si = r_cfg_si;
  assign cfg_en = r_cfg_en;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

  // NOTE: every register below is state, so it is written only with
  // non-blocking assignments; blocking writes here would make the result
  // depend on statement order and simulate differently from the netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_wbit   <= '0;
      r_tbit   <= '0;
      r_cfg_si <= 1'b0;
      r_cfg_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state  <= S_IDLE;
        r_cfg_si <= 1'b0;
        r_cfg_en <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_LOAD;
              r_tbit  <= '0;
              r_wbit  <= '0;
            end
          end
          S_LOAD: begin
            // Bit 0 goes straight onto cfg_si; the rest waits in r_sreg.
            if (w_accept) begin
              r_state  <= S_SHIFT;
              r_sreg   <= in_data[WORD_W-1:1];
              r_cfg_si <= in_data[0];
              r_cfg_en <= 1'b1;
              r_wbit   <= '0;
            end
          end
          S_SHIFT: begin
            r_tbit <= r_tbit + 1'b1;
            r_wbit <= r_wbit + 1'b1;
            // The chain-length test comes first so a partial final word
            // ends the load without waiting for its unused upper bits.
            if (w_last_bit) begin
              r_state  <= S_DONE;
              r_cfg_si <= 1'b0;
              r_cfg_en <= 1'b0;
              r_done   <= 1'b1;
            end else if (w_word_end) begin
              r_state  <= S_LOAD;
              r_cfg_si <= 1'b0;
              r_cfg_en <= 1'b0;
            end else begin
              r_cfg_si <= r_sreg[0];
              r_sreg   <= r_sreg >> 1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] r_rb_shift;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_rb_next;

  // r_cfg_en is high exactly while a bit is being shifted, and r_wbit is
  // that bit's position in its word, so the tail sample lands in place.
  assign w_rb_next = r_rb_shift | (WORD_W'(cfg_so) << r_wbit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_shift <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_abort) begin
        r_rb_shift <= '0;
      end else if (r_cfg_en) begin
        if (w_last_bit || w_word_end) begin
          r_rb_data  <= w_rb_next;
          r_rb_valid <= 1'b1;
          r_rb_shift <= '0;
        end else begin
          r_rb_shift <= w_rb_next;
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_cfg_so;

  assign w_unused_cfg_so = cfg_so;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
`timescale 1ns/1ps
module tb_cfg_chain_loader;

  localparam int LA = 40;
  localparam int WA = 8;
  localparam int NA = (LA + WA - 1) / WA;
  localparam int LB = 5;
  localparam int WB = 4;
  localparam int NB = (LB + WB - 1) / WB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b, abort_a, abort_b, in_valid;
  logic [7:0] in_data;
  logic       in_ready_a, cfg_si_a, cfg_en_a, cfg_so_a, busy_a, done_a, rb_valid_a;
  logic [7:0] rb_data_a;
  logic       in_ready_b, cfg_si_b, cfg_en_b, cfg_so_b, busy_b, done_b, rb_valid_b;
  logic [3:0] rb_data_b;

  always #5 clk = ~clk;

  cfg_chain_loader #(.CHAIN_LEN(LA), .WORD_W(WA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .cfg_si(cfg_si_a), .cfg_en(cfg_en_a), .cfg_so(cfg_so_a),
    .busy(busy_a), .done(done_a), .rb_data(rb_data_a), .rb_valid(rb_valid_a)
  );

  cfg_chain_loader #(.CHAIN_LEN(LB), .WORD_W(WB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .in_data(in_data[3:0]), .in_valid(in_valid), .in_ready(in_ready_b),
    .cfg_si(cfg_si_b), .cfg_en(cfg_en_b), .cfg_so(cfg_so_b),
    .busy(busy_b), .done(done_b), .rb_data(rb_data_b), .rb_valid(rb_valid_b)
  );

  // Behavioural scan chains: head enters at the MSB, tail (bit 0) exits first.
  logic [LA-1:0] chain_a;
  logic [LB-1:0] chain_b;
  logic          preload_req;
  logic [39:0]   preload_val;

  always @(posedge clk) begin
    if (preload_req) begin
      chain_a <= preload_val;
      chain_b <= preload_val[LB-1:0];
    end else begin
      if (cfg_en_a) chain_a <= {cfg_si_a, chain_a[LA-1:1]};
      if (cfg_en_b) chain_b <= {cfg_si_b, chain_b[LB-1:1]};
    end
  end

  assign cfg_so_a = chain_a[0];
  assign cfg_so_b = chain_b[0];

  int         checks = 0;
  int         errors = 0;
  bit         si_log[$];
  logic [7:0] rb_log[$];
  logic [7:0] src_q[$];
  logic [7:0] word_copy[$];
  int         n_shifts, n_done, done_cyc, n_rb, rb_timing_bad;
  int         stall_bad, stall_seen, abort_bad;
  bit         timeout;
  logic       last_busy;

  function automatic logic f_ready(bit sm); return sm ? in_ready_b : in_ready_a; endfunction
  function automatic logic f_en(bit sm);    return sm ? cfg_en_b   : cfg_en_a;   endfunction
  function automatic logic f_si(bit sm);    return sm ? cfg_si_b   : cfg_si_a;   endfunction
  function automatic logic f_busy(bit sm);  return sm ? busy_b     : busy_a;     endfunction
  function automatic logic f_done(bit sm);  return sm ? done_b     : done_a;     endfunction
  function automatic logic f_rbv(bit sm);   return sm ? rb_valid_b : rb_valid_a; endfunction
  function automatic logic [7:0] f_rbd(bit sm);
    return sm ? {4'h0, rb_data_b} : rb_data_a;
  endfunction
  function automatic logic [39:0] f_chain(bit sm);
    return sm ? {35'h0, chain_b} : chain_a;
  endfunction

  // Reference model: the chain bit stream is the word stream laid end to end,
  // LSB first, cut at L bits.
  function automatic bit exp_bit(int i, int w);
    logic [7:0] wd;
    wd = word_copy[i / w];
    return wd[i % w];
  endfunction

  function automatic int si_mismatch(int l, int w);
    int m = 0;
    for (int i = 0; i < l && i < si_log.size(); i++)
      if (si_log[i] !== exp_bit(i, w)) m++;
    return m;
  endfunction

  function automatic logic [39:0] exp_chain(int l, int w);
    logic [39:0] v = '0;
    for (int i = 0; i < l; i++) v[i] = exp_bit(i, w);
    return v;
  endfunction

  // Runs one load on DUT a (sm=0) or b (sm=1) from the words in src_q.
  // stall_word: after that many accepted words, withhold in_valid for
  // stall_len cycles in which the DUT is waiting. abort_at/restart_at:
  // pulse abort/start once the given number of shifts has been seen.
  task automatic do_load(input bit sm, input int stall_word, input int stall_len,
                         input int abort_at, input int restart_at);
    int          cyc, end_at, words_acc, stall_left, abort_cyc;
    bit          accept, stalled, prev_en, restarted;
    logic [39:0] snap;
    si_log.delete();
    rb_log.delete();
    n_shifts = 0; n_done = 0; done_cyc = -1; n_rb = 0; rb_timing_bad = 0;
    stall_bad = 0; stall_seen = 0; abort_bad = 0; timeout = 0;
    words_acc = 0; stall_left = 0; abort_cyc = -1; end_at = -1;
    stalled = 0; prev_en = 0; restarted = 0; snap = '0;
    word_copy = src_q;
    @(negedge clk);
    if (sm) start_b = 1'b1; else start_a = 1'b1;
    in_valid = (src_q.size() > 0);
    if (src_q.size() > 0) in_data = src_q[0];
    cyc = 0;
    while (cyc != end_at && cyc < 600) begin
      #1;
      accept = in_valid && f_ready(sm);
      @(negedge clk);
      cyc++;
      start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
      if (accept) begin
        void'(src_q.pop_front());
        words_acc++;
        if (words_acc == stall_word) stall_left = stall_len;
      end
      if (stalled && f_chain(sm) !== snap) stall_bad++;
      stalled = 1'b0;
      if (f_en(sm)) begin
        si_log.push_back(f_si(sm));
        n_shifts++;
      end
      if (f_rbv(sm)) begin
        rb_log.push_back(f_rbd(sm));
        n_rb++;
        if (!(prev_en && !f_en(sm))) rb_timing_bad++;
      end
      prev_en = f_en(sm);
      if (f_done(sm)) begin
        n_done++;
        done_cyc = cyc;
        if (end_at < 0) end_at = cyc + 2;
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        if (f_busy(sm) !== 1'b0 || f_en(sm) !== 1'b0 || f_ready(sm) !== 1'b0 || f_done(sm) !== 1'b0)
          abort_bad++;
        end_at = cyc + 6;
      end
      if (abort_at >= 0 && abort_cyc < 0 && n_shifts == abort_at) begin
        if (sm) abort_b = 1'b1; else abort_a = 1'b1;
        abort_cyc = cyc;
      end
      if (restart_at >= 0 && !restarted && n_shifts == restart_at) begin
        if (sm) start_b = 1'b1; else start_a = 1'b1;
        restarted = 1'b1;
      end
      if (stall_left > 0 && f_ready(sm)) begin
        in_valid = 1'b0;
        stall_left--;
        stall_seen++;
        stalled = 1'b1;
        snap = f_chain(sm);
        if (f_en(sm) !== 1'b0) stall_bad++;
      end else begin
        in_valid = (src_q.size() > 0);
        if (src_q.size() > 0) in_data = src_q[0];
      end
    end
    timeout   = (cyc != end_at);
    last_busy = f_busy(sm);
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0; in_valid = 1'b0;
    src_q.delete();
  endtask

  task automatic preload(input logic [39:0] v);
    @(negedge clk);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy_a, cfg_en_a, cfg_si_a, in_ready_a, done_a, rb_valid_a, rb_data_a} !== 14'h0) begin
      errors++;
      $display("FAIL reset_state_a: got %b required 0",
               {busy_a, cfg_en_a, cfg_si_a, in_ready_a, done_a, rb_valid_a, rb_data_a});
    end
    checks++;
    if ({busy_b, cfg_en_b, cfg_si_b, in_ready_b, done_b, rb_valid_b, rb_data_b} !== 10'h0) begin
      errors++;
      $display("FAIL reset_state_b: got %b required 0",
               {busy_b, cfg_en_b, cfg_si_b, in_ready_b, done_b, rb_valid_b, rb_data_b});
    end
    preload(40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Start a load and pull reset while it is shifting.
    @(negedge clk);
    start_a = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cfg_en_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_shift: cfg_en=%b busy=%b required 1 1", cfg_en_a, busy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, cfg_en_a, in_ready_a, done_a} !== 4'b0) begin
      errors++;
      $display("FAIL reset_async: busy,cfg_en,in_ready,done=%b required 0000",
               {busy_a, cfg_en_a, in_ready_a, done_a});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy_a, cfg_en_a, in_ready_a} !== 3'b0) begin
      errors++;
      $display("FAIL reset_needs_start: busy,cfg_en,in_ready=%b required 000",
               {busy_a, cfg_en_a, in_ready_a});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_chain;
    src_q = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5};
    do_load(1'b0, -1, 0, -1, -1);
    checks++;
    if (timeout || n_shifts != LA) begin
      errors++;
      $display("FAIL full_shifts: got %0d (timeout=%0d) required %0d", n_shifts, timeout, LA);
    end
    checks++;
    if (si_mismatch(LA, WA) != 0) begin
      errors++;
      $display("FAIL full_si_seq: %0d bits wrong required 0", si_mismatch(LA, WA));
    end
    checks++;
    if (n_done != 1 || done_cyc != 1 + NA + LA) begin
      errors++;
      $display("FAIL full_done: pulses=%0d cycle=%0d required 1 at %0d", n_done, done_cyc, 1 + NA + LA);
    end
    checks++;
    if (chain_a !== exp_chain(LA, WA)) begin
      errors++;
      $display("FAIL full_chain: got %h required %h", chain_a, exp_chain(LA, WA));
    end
  endtask

  task automatic test_partial_word;
    src_q = '{8'h03, 8'h0F};
    do_load(1'b1, -1, 0, -1, -1);
    checks++;
    if (timeout || n_shifts != LB) begin
      errors++;
      $display("FAIL partial_shifts: got %0d required %0d", n_shifts, LB);
    end
    checks++;
    if (si_mismatch(LB, WB) != 0) begin
      errors++;
      $display("FAIL partial_si_seq: %0d bits wrong required 0", si_mismatch(LB, WB));
    end
    checks++;
    if (n_done != 1 || done_cyc != 1 + NB + LB) begin
      errors++;
      $display("FAIL partial_done: pulses=%0d cycle=%0d required 1 at %0d", n_done, done_cyc, 1 + NB + LB);
    end
    checks++;
    if (chain_b !== 5'b10011) begin
      errors++;
      $display("FAIL partial_chain: got %b required 10011", chain_b);
    end
  endtask

  task automatic test_stall;
    src_q = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5};
    do_load(1'b0, 2, 10, -1, -1);
    checks++;
    if (stall_seen != 10 || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: stall cycles=%0d violations=%0d required 10 0", stall_seen, stall_bad);
    end
    checks++;
    if (n_shifts != LA || si_mismatch(LA, WA) != 0) begin
      errors++;
      $display("FAIL stall_data: shifts=%0d wrong bits=%0d required %0d 0", n_shifts, si_mismatch(LA, WA), LA);
    end
    checks++;
    if (timeout || n_done != 1 || done_cyc != 1 + NA + LA + 10) begin
      errors++;
      $display("FAIL stall_done: pulses=%0d cycle=%0d required 1 at %0d", n_done, done_cyc, 1 + NA + LA + 10);
    end
  endtask

  task automatic test_abort;
    for (int i = 0; i < NA; i++) src_q.push_back(8'($urandom));
    do_load(1'b0, -1, 0, 13, -1);
    checks++;
    if (n_shifts != 13 || abort_bad != 0) begin
      errors++;
      $display("FAIL abort_stop: shifts=%0d bad_state=%0d required 13 0", n_shifts, abort_bad);
    end
    checks++;
    if (n_done != 0 || last_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d busy=%b required 0 0", n_done, last_busy);
    end
    for (int i = 0; i < NA; i++) src_q.push_back(8'($urandom));
    do_load(1'b0, -1, 0, -1, -1);
    checks++;
    if (timeout || n_shifts != LA || si_mismatch(LA, WA) != 0 || chain_a !== exp_chain(LA, WA)) begin
      errors++;
      $display("FAIL abort_reload: shifts=%0d chain=%h required %0d %h",
               n_shifts, chain_a, LA, exp_chain(LA, WA));
    end
    checks++;
    if (n_done != 1 || done_cyc != 1 + NA + LA) begin
      errors++;
      $display("FAIL abort_reload_done: pulses=%0d cycle=%0d required 1 at %0d", n_done, done_cyc, 1 + NA + LA);
    end
  endtask

  task automatic test_readback;
    logic [39:0] pre;
    logic [7:0]  exp_w;
    int          bad;
    pre = 40'h0123456789;
    for (int s = 0; s < 2; s++) begin
      int l = (s == 0) ? LA : LB;
      int w = (s == 0) ? WA : WB;
      int n = (s == 0) ? NA : NB;
      preload(pre);
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
      do_load(s[0], -1, 0, -1, -1);
`ifdef CFG_READBACK_EN
      bad = 0;
      for (int k = 0; k < n && k < rb_log.size(); k++) begin
        exp_w = '0;
        for (int j = 0; j < w; j++)
          if (k * w + j < l) exp_w[j] = pre[k * w + j];
        if (rb_log[k] !== exp_w) bad++;
      end
      checks++;
      if (n_rb != n || rb_timing_bad != 0) begin
        errors++;
        $display("FAIL rb_strobes_%0d: pulses=%0d mistimed=%0d required %0d 0", s, n_rb, rb_timing_bad, n);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rb_data_%0d: %0d words wrong required 0", s, bad);
      end
`else
      bad = 0;
      checks++;
      if (n_rb != 0 || f_rbd(s[0]) !== 8'h00) begin
        errors++;
        $display("FAIL rb_absent_%0d: pulses=%0d data=%h required 0 00", s, n_rb, f_rbd(s[0]));
      end
`endif
      checks++;
      if (timeout || si_mismatch(l, w) != 0 || f_chain(s[0]) !== exp_chain(l, w)) begin
        errors++;
        $display("FAIL rb_load_%0d: chain=%h required %h", s, f_chain(s[0]), exp_chain(l, w));
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      bit sm = it[0];
      int l  = sm ? LB : LA;
      int w  = sm ? WB : WA;
      int n  = sm ? NB : NA;
      int sw = $urandom_range(n - 1, 1);
      int sl = $urandom_range(6, 0);
      int ra = $urandom_range(l - 1, 1);
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
      do_load(sm, sw, sl, -1, ra);
      checks++;
      if (timeout || n_shifts != l || si_mismatch(l, w) != 0) begin
        errors++;
        $display("FAIL rand_%0d_stream: shifts=%0d wrong bits=%0d required %0d 0",
                 it, n_shifts, si_mismatch(l, w), l);
      end
      checks++;
      if (n_done != 1 || done_cyc != 1 + n + l + sl || last_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d_done: pulses=%0d cycle=%0d busy_after=%b required 1 at %0d busy 0",
                 it, n_done, done_cyc, last_busy, 1 + n + l + sl);
      end
      checks++;
      if (f_chain(sm) !== exp_chain(l, w) || stall_bad != 0) begin
        errors++;
        $display("FAIL rand_%0d_chain: got %h stall violations %0d required %h 0",
                 it, f_chain(sm), stall_bad, exp_chain(l, w));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    preload_req = 1'b0; preload_val = '0;
    test_reset();
    test_full_chain();
    test_partial_word();
    test_stall();
    test_abort();
    test_readback();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
